// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle RV32I controller: opcodes, FSM state
// encoding, datapath mux-select codes, trap causes and the control word.
package cpu_defs;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTE_R,
    S_EXECUTE_I,
    S_ALUWB,
    S_BEQ,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_READ_DATA  = 2'b01;
  localparam logic [1:0] RES_ALU_DIRECT = 2'b10;
  localparam logic [1:0] RES_IMM        = 2'b11;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_t;

  // fetch_advance marks the fetch state: IR load and PC+4 update both wait
  // for the memory handshake, so the top level qualifies it with mem_ready.
  typedef struct packed {
    logic       mem_request;
    logic       mem_write;
    logic       adr_select;
    logic       fetch_advance;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] result_select;
  } control_word_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/controller_output_decoder.sv
// Moore control-word decoder: maps the current FSM state onto the datapath
// enables and mux selects. Anything a state does not mention stays 0.
module controller_output_decoder
  import cpu_defs::*;
(
  input  state_t        state,
  output control_word_t control
);

  // Default everything to 0, then raise only the fields each state uses.
  always_comb begin
    control = '0;
    case (state)
      S_FETCH: begin
        control.mem_request   = 1'b1;
        control.fetch_advance = 1'b1;
        control.src_a         = SRC_A_PC;
        control.src_b         = SRC_B_FOUR;
        control.alu_op        = ALU_OP_ADD;
        control.result_select = RES_ALU_DIRECT;
      end
      S_DECODE: begin
        control.src_a  = SRC_A_OLD_PC;
        control.src_b  = SRC_B_IMM;
        control.alu_op = ALU_OP_ADD;
      end
      S_MEMADR: begin
        control.src_a  = SRC_A_RS1;
        control.src_b  = SRC_B_IMM;
        control.alu_op = ALU_OP_ADD;
      end
      S_MEMREAD: begin
        control.mem_request = 1'b1;
        control.adr_select  = 1'b1;
      end
      S_MEMWB: begin
        control.result_select = RES_READ_DATA;
        control.reg_write     = 1'b1;
      end
      S_MEMWRITE: begin
        control.mem_request = 1'b1;
        control.mem_write   = 1'b1;
        control.adr_select  = 1'b1;
      end
      S_EXECUTE_R: begin
        control.src_a  = SRC_A_RS1;
        control.src_b  = SRC_B_RS2;
        control.alu_op = ALU_OP_FUNCT;
      end
      S_EXECUTE_I: begin
        control.src_a  = SRC_A_RS1;
        control.src_b  = SRC_B_IMM;
        control.alu_op = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        control.result_select = RES_ALU_OUT;
        control.reg_write     = 1'b1;
      end
      S_BEQ: begin
        control.src_a         = SRC_A_RS1;
        control.src_b         = SRC_B_RS2;
        control.alu_op        = ALU_OP_SUB;
        control.result_select = RES_ALU_OUT;
        control.branch        = 1'b1;
      end
      S_JAL: begin
        control.src_a         = SRC_A_OLD_PC;
        control.src_b         = SRC_B_FOUR;
        control.alu_op        = ALU_OP_ADD;
        control.result_select = RES_ALU_OUT;
        control.pc_update     = 1'b1;
      end
      S_LUI: begin
        control.result_select = RES_IMM;
        control.reg_write     = 1'b1;
      end
      default: control = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I datapath: state register,
// next-state logic, memory wait watchdog and sticky trap latch. The control
// word itself comes from controller_output_decoder.
module multicycle_controller
  import cpu_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_request,
  output logic       mem_write,
  output logic       adr_select,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] ALU_src_a,
  output logic [1:0] ALU_src_b,
  output logic [1:0] ALU_op,
  output logic [1:0] result_select,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  // The last waiting cycle is the one where the count is about to reach
  // TIMEOUT_CYCLES, so the trap lands after exactly TIMEOUT_CYCLES waits.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t        state;
  state_t        next_state;
  trap_cause_t   pending_cause;
  trap_cause_t   cause_q;
  logic [WAIT_W-1:0] wait_count;
  logic          waiting;
  logic          wait_expired;
  control_word_t control;

  controller_output_decoder u_decoder (
    .state   (state),
    .control (control)
  );

  // A memory state with no ready this cycle is a wait cycle; ready always
  // beats an expiring watchdog.
  always_comb begin
    waiting      = is_mem_state(state) && !mem_ready;
    wait_expired = waiting && (wait_count == WAIT_LAST);
  end

  // Next-state selection, with the watchdog overriding any stalled state.
  always_comb begin
    next_state    = state;
    pending_cause = CAUSE_NONE;
    case (state)
      S_FETCH:     if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECUTE_R;
          OP_I:              next_state = S_EXECUTE_I;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          OP_LUI:            next_state = S_LUI;
          default: begin
            next_state    = S_TRAP;
            pending_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:    next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:   if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:     next_state = S_FETCH;
      S_MEMWRITE:  if (mem_ready) next_state = S_FETCH;
      S_EXECUTE_R: next_state = S_ALUWB;
      S_EXECUTE_I: next_state = S_ALUWB;
      S_ALUWB:     next_state = S_FETCH;
      S_BEQ:       next_state = S_FETCH;
      S_JAL:       next_state = S_ALUWB;
      S_LUI:       next_state = S_FETCH;
      S_TRAP:      next_state = S_TRAP;
      default:     next_state = S_FETCH;
    endcase
    if (wait_expired) begin
      next_state    = S_TRAP;
      pending_cause = CAUSE_TIMEOUT;
    end
  end

  // State register; reset abandons whatever instruction was in flight.
  always_ff @(posedge clock) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Wait counter counts consecutive stalled memory cycles; every non-waiting
  // cycle clears it, so each memory state starts counting from 0.
  always_ff @(posedge clock) begin
    if (reset)                        wait_count <= '0;
    else if (waiting && !wait_expired) wait_count <= wait_count + WAIT_W'(1);
    else                              wait_count <= '0;
  end

  // Trap flag and cause capture the first trap only and hold until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      trap    <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else if (!trap && next_state == S_TRAP) begin
      trap    <= 1'b1;
      cause_q <= pending_cause;
    end
  end

  assign trap_cause = cause_q;

  // Enables are suppressed while reset is high so nothing is written after a
  // mid-instruction reset; selects pass straight through.
  always_comb begin
    mem_request   = control.mem_request & ~reset;
    mem_write     = control.mem_write & ~reset;
    ir_write      = control.fetch_advance & mem_ready & ~reset;
    pc_write      = ~reset & (control.pc_update
                              | (control.fetch_advance & mem_ready)
                              | (control.branch & zero));
    reg_write     = control.reg_write & ~reset;
    adr_select    = control.adr_select;
    ALU_src_a     = control.src_a;
    ALU_src_b     = control.src_b;
    ALU_op        = control.alu_op;
    result_select = control.result_select;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller. Outputs are packed into one
// 17-bit word {mem_request, mem_write, adr_select, ir_write, pc_write,
// reg_write, ALU_src_a, ALU_src_b, ALU_op, result_select, trap, trap_cause}
// and compared against hand-written per-state words.
module tb_multicycle_controller;

  localparam logic [16:0] CW_FETCH_RDY  = {6'b100110, 8'b00_10_00_10, 3'b000};
  localparam logic [16:0] CW_FETCH_WAIT = {6'b100000, 8'b00_10_00_10, 3'b000};
  localparam logic [16:0] CW_RESET      = {6'b000000, 8'b00_10_00_10, 3'b000};
  localparam logic [16:0] CW_DECODE     = {6'b000000, 8'b01_01_00_00, 3'b000};
  localparam logic [16:0] CW_MEMADR     = {6'b000000, 8'b10_01_00_00, 3'b000};
  localparam logic [16:0] CW_MEMREAD    = {6'b101000, 8'b00_00_00_00, 3'b000};
  localparam logic [16:0] CW_MEMWB      = {6'b000001, 8'b00_00_00_01, 3'b000};
  localparam logic [16:0] CW_MEMWRITE   = {6'b111000, 8'b00_00_00_00, 3'b000};
  localparam logic [16:0] CW_MEMWR_RST  = {6'b001000, 8'b00_00_00_00, 3'b000};
  localparam logic [16:0] CW_EXEC_R     = {6'b000000, 8'b10_00_10_00, 3'b000};
  localparam logic [16:0] CW_EXEC_I     = {6'b000000, 8'b10_01_10_00, 3'b000};
  localparam logic [16:0] CW_ALUWB      = {6'b000001, 8'b00_00_00_00, 3'b000};
  localparam logic [16:0] CW_BEQ_TAKEN  = {6'b000010, 8'b10_00_01_00, 3'b000};
  localparam logic [16:0] CW_BEQ_NOT    = {6'b000000, 8'b10_00_01_00, 3'b000};
  localparam logic [16:0] CW_JAL        = {6'b000010, 8'b01_10_00_00, 3'b000};
  localparam logic [16:0] CW_LUI        = {6'b000001, 8'b00_00_00_11, 3'b000};
  localparam logic [16:0] CW_TRAP_ILL   = {6'b000000, 8'b00_00_00_00, 3'b101};
  localparam logic [16:0] CW_TRAP_TO    = {6'b000000, 8'b00_00_00_00, 3'b110};

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_request, mem_write, adr_select, ir_write, pc_write, reg_write;
  logic [1:0] ALU_src_a, ALU_src_b, ALU_op, result_select, trap_cause;
  logic       trap;

  logic       t_mem_request, t_mem_write, t_adr_select, t_ir_write, t_pc_write, t_reg_write;
  logic [1:0] t_ALU_src_a, t_ALU_src_b, t_ALU_op, t_result_select, t_trap_cause;
  logic       t_trap;

  logic [16:0] cw;
  logic [16:0] cw_to;

  int checks = 0;
  int passes = 0;

  assign cw = {mem_request, mem_write, adr_select, ir_write, pc_write, reg_write,
               ALU_src_a, ALU_src_b, ALU_op, result_select, trap, trap_cause};
  assign cw_to = {t_mem_request, t_mem_write, t_adr_select, t_ir_write, t_pc_write, t_reg_write,
                  t_ALU_src_a, t_ALU_src_b, t_ALU_op, t_result_select, t_trap, t_trap_cause};

  always #5 clock = ~clock;

  multicycle_controller dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_request(mem_request), .mem_write(mem_write), .adr_select(adr_select),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b), .ALU_op(ALU_op),
    .result_select(result_select), .trap(trap), .trap_cause(trap_cause)
  );

  multicycle_controller #(.TIMEOUT_CYCLES(4)) dut_to (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_request(t_mem_request), .mem_write(t_mem_write), .adr_select(t_adr_select),
    .ir_write(t_ir_write), .pc_write(t_pc_write), .reg_write(t_reg_write),
    .ALU_src_a(t_ALU_src_a), .ALU_src_b(t_ALU_src_b), .ALU_op(t_ALU_op),
    .result_select(t_result_select), .trap(t_trap), .trap_cause(t_trap_cause)
  );

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_R;
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (cw !== CW_RESET) $display("[TB] FAIL reset_hold: cw=%b expected %b", cw, CW_RESET);
    else passes++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cw !== CW_FETCH_RDY) $display("[TB] FAIL reset_release: cw=%b expected %b", cw, CW_FETCH_RDY);
    else passes++;
  endtask

  task automatic test_r_type();
    logic [16:0] exp_seq [5] = '{CW_FETCH_RDY, CW_DECODE, CW_EXEC_R, CW_ALUWB, CW_FETCH_RDY};
    do_reset();
    opcode = OP_R;
    mem_ready = 1'b1;
    foreach (exp_seq[i]) begin
      @(negedge clock);
      checks++;
      if (cw !== exp_seq[i]) $display("[TB] FAIL r_type cycle %0d: cw=%b expected %b", i, cw, exp_seq[i]);
      else passes++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_lw_stall();
    logic [16:0] exp_seq [9] = '{CW_FETCH_RDY, CW_DECODE, CW_MEMADR, CW_MEMREAD, CW_MEMREAD,
                                 CW_MEMREAD, CW_MEMREAD, CW_MEMWB, CW_FETCH_RDY};
    logic rdy_seq [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int read_requests = 0;
    int writes = 0;
    do_reset();
    opcode = OP_LOAD;
    foreach (exp_seq[i]) begin
      mem_ready = rdy_seq[i];
      @(negedge clock);
      checks++;
      if (cw !== exp_seq[i]) $display("[TB] FAIL lw_stall cycle %0d: cw=%b expected %b", i, cw, exp_seq[i]);
      else passes++;
      if (i < 8 && mem_request && adr_select) read_requests++;
      if (i < 8 && reg_write) writes++;
      @(posedge clock); #1;
    end
    checks++;
    if (read_requests !== 4) $display("[TB] FAIL lw_read_requests: got %0d expected 4", read_requests);
    else passes++;
    checks++;
    if (writes !== 1) $display("[TB] FAIL lw_reg_writes: got %0d expected 1", writes);
    else passes++;
  endtask

  task automatic test_beq(input logic zero_value);
    logic [16:0] exp_seq [4];
    exp_seq = '{CW_FETCH_RDY, CW_DECODE, CW_BEQ_NOT, CW_FETCH_RDY};
    if (zero_value) exp_seq[2] = CW_BEQ_TAKEN;
    do_reset();
    opcode = OP_BRANCH;
    zero = zero_value;
    mem_ready = 1'b1;
    foreach (exp_seq[i]) begin
      @(negedge clock);
      checks++;
      if (cw !== exp_seq[i]) $display("[TB] FAIL beq_zero%0d cycle %0d: cw=%b expected %b", zero_value, i, cw, exp_seq[i]);
      else passes++;
      @(posedge clock); #1;
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [16:0] exp_seq [5] = '{CW_FETCH_RDY, CW_DECODE, CW_JAL, CW_ALUWB, CW_FETCH_RDY};
    do_reset();
    opcode = OP_JAL;
    mem_ready = 1'b1;
    foreach (exp_seq[i]) begin
      @(negedge clock);
      checks++;
      if (cw !== exp_seq[i]) $display("[TB] FAIL jal cycle %0d: cw=%b expected %b", i, cw, exp_seq[i]);
      else passes++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_seq [12] = '{CW_FETCH_RDY, CW_DECODE, CW_EXEC_I, CW_ALUWB,
                                  CW_FETCH_RDY, CW_DECODE, CW_LUI,
                                  CW_FETCH_RDY, CW_DECODE, CW_MEMADR, CW_MEMWRITE, CW_FETCH_RDY};
    logic [6:0] op_seq [12] = '{OP_I, OP_I, OP_I, OP_I, OP_LUI, OP_LUI, OP_LUI,
                                OP_STORE, OP_STORE, OP_STORE, OP_STORE, OP_R};
    do_reset();
    mem_ready = 1'b1;
    foreach (exp_seq[i]) begin
      opcode = op_seq[i];
      @(negedge clock);
      checks++;
      if (cw !== exp_seq[i]) $display("[TB] FAIL back_to_back cycle %0d: cw=%b expected %b", i, cw, exp_seq[i]);
      else passes++;
      @(posedge clock); #1;
    end
  endtask

  task automatic test_illegal();
    int bad_cycles = 0;
    do_reset();
    opcode = OP_BAD;
    mem_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (cw !== CW_FETCH_RDY) $display("[TB] FAIL illegal_fetch: cw=%b expected %b", cw, CW_FETCH_RDY);
    else passes++;
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (cw !== CW_DECODE) $display("[TB] FAIL illegal_decode: cw=%b expected %b", cw, CW_DECODE);
    else passes++;
    @(posedge clock); #1;
    opcode = OP_R;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (cw !== CW_TRAP_ILL) bad_cycles++;
      @(posedge clock); #1;
    end
    checks++;
    if (bad_cycles !== 0) $display("[TB] FAIL illegal_trap_hold: %0d cycles differed from %b, last cw=%b", bad_cycles, CW_TRAP_ILL, cw);
    else passes++;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cw !== CW_FETCH_RDY) $display("[TB] FAIL illegal_reset_exit: cw=%b expected %b", cw, CW_FETCH_RDY);
    else passes++;
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = OP_R;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (cw_to !== CW_FETCH_WAIT) $display("[TB] FAIL timeout_wait cycle %0d: cw=%b expected %b", i, cw_to, CW_FETCH_WAIT);
      else passes++;
      @(posedge clock); #1;
    end
    @(negedge clock);
    checks++;
    if (cw_to !== CW_TRAP_TO) $display("[TB] FAIL timeout_trap: cw=%b expected %b", cw_to, CW_TRAP_TO);
    else passes++;
    checks++;
    if (cw !== CW_FETCH_WAIT) $display("[TB] FAIL timeout_long_limit: cw=%b expected %b", cw, CW_FETCH_WAIT);
    else passes++;
  endtask

  task automatic test_reset_mid_sw();
    logic [16:0] exp_seq [4] = '{CW_FETCH_RDY, CW_DECODE, CW_MEMADR, CW_MEMWRITE};
    logic rdy_seq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    opcode = OP_STORE;
    foreach (exp_seq[i]) begin
      mem_ready = rdy_seq[i];
      @(negedge clock);
      checks++;
      if (cw !== exp_seq[i]) $display("[TB] FAIL reset_sw cycle %0d: cw=%b expected %b", i, cw, exp_seq[i]);
      else passes++;
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (cw !== CW_MEMWR_RST) $display("[TB] FAIL reset_sw_during: cw=%b expected %b", cw, CW_MEMWR_RST);
    else passes++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cw !== CW_FETCH_WAIT) $display("[TB] FAIL reset_sw_after: cw=%b expected %b", cw, CW_FETCH_WAIT);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_r_type();
    test_lw_stall();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_sw();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle RV32I datapath. It shares one ALU and one unified instruction/data memory port across fetch, address, execute and writeback cycles.
- Moore-style control-word generation with a memory ready/request handshake and a bounded-wait watchdog.
- Replaces the single-cycle decode path. Drives the PC/IR/register-file enables, mux selects and the ALU_op code consumed by the existing ALU decoder.

Parameters:
TIMEOUT_CYCLES, 255, max cycles a memory state waits for mem_ready before trapping (1..2^16-1)

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; sampled on rising clock edge
opcode  input  7  instr[6:0] from IR (valid from DECODE onward)
zero  input  1  ALU zero flag, combinational from current cycle
mem_ready  input  1  memory completes the current request this cycle
mem_request  output  1  memory access active this cycle
mem_write  output  1  write strobe (qualifies mem_request)
adr_select  output  1  0 = PC, 1 = ALU result register
ir_write  output  1  load IR and old_pc
pc_write  output  1  PC load enable = pc_update OR (branch AND zero)
reg_write  output  1  register-file write enable
ALU_src_a  output  2  00 PC, 01 old_pc, 10 rs1
ALU_src_b  output  2  00 rs2, 01 immediate, 10 constant 4
ALU_op  output  2  00 add, 01 subtract/compare, 10 funct-decoded
result_select  output  2  00 ALU result register, 01 read data, 10 ALU direct, 11 immediate
trap  output  1  sticky: illegal opcode or memory timeout
trap_cause  output  2  00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Reset:
  - On the reset edge: state <= FETCH, wait counter <= 0, trap <= 0, trap_cause <= 00.
  - While reset is high, all enables are forced 0: mem_request, mem_write, ir_write, pc_write, reg_write.
  - Reset mid-instruction abandons the instruction; no partial write occurs after the reset edge.
- Outputs: decoded from state only, except pc_write, which also uses zero. Unlisted outputs in each state are 0.
- States, outputs and transitions:
  - FETCH: mem_request=1, adr_select=0, ALU_src_a=00, ALU_src_b=10, ALU_op=00, result_select=10. ir_write = pc_update = mem_ready. Stay until mem_ready, then go to DECODE.
  - DECODE: ALU_src_a=01, ALU_src_b=01, ALU_op=00 (branch target into ALU result register). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTE_R
    - 0010011 -> EXECUTE_I
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - 0110111 -> LUI
    - any other -> TRAP with cause 01
  - MEMADR: ALU_src_a=10, ALU_src_b=01, ALU_op=00. Next: MEMREAD if opcode=0000011, else MEMWRITE.
  - MEMREAD: mem_request=1, adr_select=1. Stay until mem_ready, then go to MEMWB.
  - MEMWB: result_select=01, reg_write=1. Next: FETCH.
  - MEMWRITE: mem_request=1, mem_write=1, adr_select=1. mem_write stays high until mem_ready. Next: FETCH.
  - EXECUTE_R: ALU_src_a=10, ALU_src_b=00, ALU_op=10. Next: ALUWB.
  - EXECUTE_I: ALU_src_a=10, ALU_src_b=01, ALU_op=10. Next: ALUWB.
  - ALUWB: result_select=00, reg_write=1. Next: FETCH.
  - BEQ: ALU_src_a=10, ALU_src_b=00, ALU_op=01, result_select=00, branch=1 (internal). Next: FETCH.
  - JAL: ALU_src_a=01, ALU_src_b=10, ALU_op=00, result_select=00, pc_update=1. Next: ALUWB (writes PC+4 to rd).
  - LUI: result_select=11, reg_write=1. Next: FETCH.
  - TRAP: all enables 0, trap=1. Exit only by reset.
- Wait counter:
  - Clears on entry to FETCH, MEMREAD or MEMWRITE and whenever mem_ready=1.
  - Increments each waiting cycle. On reaching TIMEOUT_CYCLES with mem_ready still 0, the next state is TRAP with cause 10.
  - Width is clog2(TIMEOUT_CYCLES+1).
  - If mem_ready and the timeout coincide, mem_ready wins.
- Latency in cycles, with mem_ready asserted on the first cycle:
  - lw 5
  - sw, R-type, I-type, jal 4
  - beq, lui 3
  - each cycle of mem_ready=0 adds one cycle.
- trap_cause latches on the first trap only.

Decomposition:
- Shared package cpu_defs: opcode constants (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_LUI), state encoding (4-bit, 13 states), mux-select constants for ALU_src_a/b, result_select and ALU_op, trap_cause codes.
- One sub-module, controller_output_decoder: purely combinational, state -> control word. The top level holds the state register, next-state logic, wait counter and trap latch.

Test Plan:
- R-type: reset 2 cycles, opcode=0110011, mem_ready=1 -> states FETCH, DECODE, EXECUTE_R, ALUWB. reg_write=1 only in cycle 4, ALU_op=10 in cycle 3.
- lw with memory stall: opcode=0000011, mem_ready low 3 cycles in MEMREAD -> 8 cycles total, mem_request high 4 cycles in MEMREAD, reg_write once with result_select=01.
- beq: opcode=1100011, zero=1 -> pc_write=1 in BEQ. Repeat with zero=0 -> pc_write=0. Return to FETCH after 3 cycles either way.
- jal: opcode=1101111 -> pc_write=1 in JAL, next ALUWB reg_write=1, then FETCH.
- Illegal and timeout: opcode=1111111 -> TRAP, trap=1, cause 01, stays through 100 cycles until reset. Separately, TIMEOUT_CYCLES=4 with mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, cause 10.
- Reset mid-sw: assert reset in MEMWRITE -> mem_write=0 that cycle, state FETCH after the edge, trap=0.
